// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and constants for the fetch stage.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package fetch_pkg;

  // Fetch sequencer control states
  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    REQ     = 3'd1,
    RESP    = 3'd2,
    HOLD    = 3'd3,
    DISCARD = 3'd4
  } fetch_state_e;

  // addi x0,x0,0 presented on instr_d whenever IF/ID holds no live instruction
  localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/fetch_skid_buf.sv
// fetch_skid_buf: one-entry {instr,pc} holding register for a response that lands while ID is stalled.
// Latency: written on the load edge, readable the cycle after.
// Backpressure: none; the owner guarantees it never loads while full.
module fetch_skid_buf #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic             unload_i,
  input  logic             clear_i,
  input  logic [WIDTH-1:0] instr_i,
  input  logic [WIDTH-1:0] pc_i,
  output logic             full_o,
  output logic [WIDTH-1:0] instr_o,
  output logic [WIDTH-1:0] pc_o
);

  logic             full_q;
  logic [WIDTH-1:0] instr_q;
  logic [WIDTH-1:0] pc_q;

  // Occupancy flag: clear/unload empty the entry, load fills it
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      full_q <= 1'b0;
    end else if (clear_i || unload_i) begin
      full_q <= 1'b0;
    end else if (load_i) begin
      full_q <= 1'b1;
    end
  end

  // Payload capture; contents are meaningless while empty
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      instr_q <= '0;
      pc_q    <= '0;
    end else if (load_i) begin
      instr_q <= instr_i;
      pc_q    <= pc_i;
    end
  end

  assign full_o  = full_q;
  assign instr_o = instr_q;
  assign pc_o    = pc_q;

endmodule

// File: rtl/fetch_sequencer.sv
// fetch_sequencer: owns the IF PC, issues one-outstanding imem reads, merges PC+4 / EX redirect / stall into IF/ID.
// Latency: imem_addr to valid_d = gnt cycle + rvalid cycle + 1 edge; back-to-back issue the cycle after a load.
// Backpressure: stall_f holds PC and IF/ID; an in-flight response is parked in the skid buffer. FETCH_PERF_CNT_EN adds perf counters.
module fetch_sequencer #(
  parameter int unsigned       WIDTH     = 32,
  parameter logic [WIDTH-1:0]  RESET_PC  = WIDTH'(fetch_pkg::DEFAULT_RESET_PC),
  parameter logic [WIDTH-1:0]  NOP_INSTR = WIDTH'(fetch_pkg::NOP_INSTR)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall_f,
  input  logic             pc_src_e,
  input  logic [WIDTH-1:0] pc_target_e,
  output logic             imem_req,
  output logic [WIDTH-1:0] imem_addr,
  input  logic             imem_gnt,
  input  logic             imem_rvalid,
  input  logic [WIDTH-1:0] imem_rdata,
  output logic [WIDTH-1:0] instr_d,
  output logic [WIDTH-1:0] pc_d,
  output logic [WIDTH-1:0] pc_plus4_d,
  output logic             valid_d
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]      perf_fetch_cnt,
  output logic [31:0]      perf_stall_cnt,
  output logic [31:0]      perf_flush_cnt
`endif
);

  import fetch_pkg::*;

  fetch_state_e     state_q, state_d;
  logic [WIDTH-1:0] npc_q, npc_d;          // address of the next fetch
  logic [WIDTH-1:0] ipc_q, ipc_d;          // address of the granted, in-flight fetch
  logic [WIDTH-1:0] pend_pc_q, pend_pc_d;  // redirect target parked behind an open request
  logic             pend_vld_q, pend_vld_d;
  logic             req_open_q, req_open_d;
  logic             id_vld_q, id_vld_d;
  logic [WIDTH-1:0] id_instr_q, id_instr_d;
  logic [WIDTH-1:0] id_pc_q, id_pc_d;
  logic [WIDTH-1:0] id_pc4_q, id_pc4_d;

  logic [WIDTH-1:0] redir_pc;
  logic             granted;
  logic             id_load;
  logic [WIDTH-1:0] id_src_instr, id_src_pc;
  logic             skid_load, skid_unload, skid_clear, skid_full;
  logic [WIDTH-1:0] skid_instr, skid_pc;

  // Targets are forced word-aligned; the low bits are simply masked off
  assign redir_pc = pc_target_e & ~WIDTH'(3);

  // Once raised, req stays up until gnt; a stalled REQ only withholds a request not yet raised
  assign imem_req  = (state_q == REQ) && (req_open_q || !stall_f);
  assign imem_addr = npc_q;
  assign granted   = imem_req && imem_gnt;

  // Control FSM next-state: redirect always wins over stall
  always_comb begin
    state_d      = state_q;
    npc_d        = npc_q;
    ipc_d        = ipc_q;
    pend_vld_d   = pend_vld_q;
    pend_pc_d    = pend_pc_q;
    req_open_d   = req_open_q;
    id_load      = 1'b0;
    id_src_instr = imem_rdata;
    id_src_pc    = ipc_q;
    skid_load    = 1'b0;
    skid_unload  = 1'b0;
    skid_clear   = 1'b0;
    case (state_q)
      IDLE: begin
        state_d = REQ;
        if (pc_src_e) npc_d = redir_pc;
      end
      REQ: begin
        if (granted) begin
          ipc_d      = npc_q;
          req_open_d = 1'b0;
          pend_vld_d = 1'b0;
          if (pc_src_e) begin
            npc_d   = redir_pc;
            state_d = DISCARD;
          end else if (pend_vld_q) begin
            npc_d   = pend_pc_q;
            state_d = DISCARD;
          end else begin
            npc_d   = npc_q + WIDTH'(4);
            state_d = RESP;
          end
        end else begin
          if (imem_req) req_open_d = 1'b1;
          if (pc_src_e) begin
            if (imem_req) begin
              pend_vld_d = 1'b1;
              pend_pc_d  = redir_pc;
            end else begin
              npc_d = redir_pc;
            end
          end
        end
      end
      RESP: begin
        if (imem_rvalid) begin
          if (pc_src_e) begin
            npc_d   = redir_pc;
            state_d = REQ;
          end else if (stall_f) begin
            skid_load = 1'b1;
            state_d   = HOLD;
          end else begin
            id_load = 1'b1;
            state_d = REQ;
          end
        end else if (pc_src_e) begin
          npc_d   = redir_pc;
          state_d = DISCARD;
        end
      end
      HOLD: begin
        if (pc_src_e) begin
          skid_clear = 1'b1;
          npc_d      = redir_pc;
          state_d    = REQ;
        end else if (!stall_f && skid_full) begin
          id_load      = 1'b1;
          id_src_instr = skid_instr;
          id_src_pc    = skid_pc;
          skid_unload  = 1'b1;
          state_d      = REQ;
        end
      end
      DISCARD: begin
        if (pc_src_e) npc_d = redir_pc;
        if (imem_rvalid) state_d = REQ;
      end
      default: state_d = IDLE;
    endcase
  end

  // IF/ID next-state: advances to a bubble unless stalled; a redirect flushes even under stall
  always_comb begin
    id_vld_d   = id_vld_q;
    id_instr_d = id_instr_q;
    id_pc_d    = id_pc_q;
    id_pc4_d   = id_pc4_q;
    if (pc_src_e || !stall_f) id_vld_d = 1'b0;
    if (id_load) begin
      id_vld_d   = 1'b1;
      id_instr_d = id_src_instr;
      id_pc_d    = id_src_pc;
      id_pc4_d   = id_src_pc + WIDTH'(4);
    end
  end

  // Control registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      npc_q      <= RESET_PC;
      ipc_q      <= '0;
      pend_vld_q <= 1'b0;
      pend_pc_q  <= '0;
      req_open_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      npc_q      <= npc_d;
      ipc_q      <= ipc_d;
      pend_vld_q <= pend_vld_d;
      pend_pc_q  <= pend_pc_d;
      req_open_q <= req_open_d;
    end
  end

  // IF/ID pipeline register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      id_vld_q   <= 1'b0;
      id_instr_q <= NOP_INSTR;
      id_pc_q    <= '0;
      id_pc4_q   <= '0;
    end else begin
      id_vld_q   <= id_vld_d;
      id_instr_q <= id_instr_d;
      id_pc_q    <= id_pc_d;
      id_pc4_q   <= id_pc4_d;
    end
  end

  fetch_skid_buf #(
    .WIDTH (WIDTH)
  ) u_skid (
    .clk      (clk),
    .rst      (rst),
    .load_i   (skid_load),
    .unload_i (skid_unload),
    .clear_i  (skid_clear),
    .instr_i  (imem_rdata),
    .pc_i     (ipc_q),
    .full_o   (skid_full),
    .instr_o  (skid_instr),
    .pc_o     (skid_pc)
  );

  assign instr_d    = id_vld_q ? id_instr_q : NOP_INSTR;
  assign pc_d       = id_pc_q;
  assign pc_plus4_d = id_pc4_q;
  assign valid_d    = id_vld_q;

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_fetch_q, perf_stall_q, perf_flush_q;

  // Saturating event counters: IF/ID loads, stalled cycles, redirects taken
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_fetch_q <= '0;
      perf_stall_q <= '0;
      perf_flush_q <= '0;
    end else begin
      if (id_load && (perf_fetch_q != '1))  perf_fetch_q <= perf_fetch_q + 32'd1;
      if (stall_f && (perf_stall_q != '1))  perf_stall_q <= perf_stall_q + 32'd1;
      if (pc_src_e && (perf_flush_q != '1)) perf_flush_q <= perf_flush_q + 32'd1;
    end
  end

  assign perf_fetch_cnt = perf_fetch_q;
  assign perf_stall_cnt = perf_stall_q;
  assign perf_flush_cnt = perf_flush_q;
`endif

endmodule
